// File: rtl/miner_uart_pkg.sv
// Shared definitions for the miner's host serial transmit path.
// Holds the serialiser state encoding and the framing constants used by
// both the byte serialiser and the nonce-level sequencer.
package miner_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int NONCE_BYTES      = 4;
  localparam int DEFAULT_BAUD_DIV = 434;
  localparam int UART_DATA_BITS   = 8;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   data         - byte to send, taken when data_valid && data_ready
//   data_valid   - a byte is offered
//   data_ready   - serialiser can take a byte this cycle (idle, or last
//                  cycle of a stop bit so bytes chain with no gap)
//   byte_done    - last cycle of the stop bit
//   idle         - FSM is in IDLE
//   txd          - serial line, high when idle
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (low) for BAUD_DIV cycles
// DATA  | 8 data bits LSB-first, BAUD_DIV cycles each
// STOP  | stop bit (high) for BAUD_DIV cycles; may chain into START
module uart_tx_byte
  import miner_uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       byte_done,
  output logic       idle,
  output logic       txd
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t      state, state_nxt;
  logic [BW-1:0]  baud_cnt, baud_nxt;
  logic [2:0]     bit_cnt, bit_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic           tick;
  logic           load;

  assign tick       = (baud_cnt == '0);
  assign byte_done  = (state == STOP) && tick;
  assign data_ready = (state == IDLE) || byte_done;
  assign load       = data_valid && data_ready;
  assign idle       = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = START;
          baud_nxt  = BAUD_LOAD;
          shreg_nxt = data;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          baud_nxt  = BAUD_LOAD;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          baud_nxt = BAUD_LOAD;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            shreg_nxt = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (load) begin
            state_nxt = START;
            baud_nxt  = BAUD_LOAD;
            shreg_nxt = data;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level comes straight from state so reset forces it high at once.
  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce transmitter: buffers nonces from the hashing core and sends
// each as four UART 8N1 bytes, most-significant byte first.
// Ports:
//   clk                - system clock
//   reset_in           - asynchronous active-low reset
//   golden_nonce       - nonce from the hasher
//   golden_nonce_valid - one-cycle capture strobe
//   txd                - serial out, idles high
//   busy               - frame on the line or FIFO non-empty
//   fifo_full          - FIFO holds FIFO_DEPTH nonces
//   overflow           - sticky, a nonce was dropped
//   drop_count         - dropped nonces, saturating at 255
module golden_nonce_uart_tx
  import miner_uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [31:0] golden_nonce,
  input  logic        golden_nonce_valid,
  output logic        txd,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] LAST_BYTE = 2'(NONCE_BYTES - 1);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          run;
  logic          active;
  logic [1:0]    byte_idx;
  logic [31:0]   hold;
  logic          push, pop, drop;
  logic          ser_valid, ser_ready, ser_done, ser_idle;
  logic [7:0]    ser_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));

  // Pops only happen between nonces, which gives the single idle cycle
  // between back-to-back frames. A pop frees a slot in the same cycle, so a
  // strobe into a full FIFO is still accepted then.
  assign pop  = !active && ser_ready && !fifo_empty;
  assign push = golden_nonce_valid && run && (!fifo_full || pop);
  assign drop = golden_nonce_valid && run && !push;

  assign ser_valid = pop || (active && (byte_idx != LAST_BYTE));
  assign ser_data  = active ? hold[31:24] : mem[rd_ptr][31:24];

  assign busy = !ser_idle || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= golden_nonce;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      run        <= 1'b0;
      active     <= 1'b0;
      byte_idx   <= '0;
      hold       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      // run masks the strobe on the first edge after reset release.
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        active   <= 1'b1;
        byte_idx <= '0;
        hold     <= {mem[rd_ptr][23:0], 8'h00};
      end else if (active && ser_done) begin
        if (byte_idx == LAST_BYTE) begin
          active <= 1'b0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          hold     <= {hold[23:0], 8'h00};
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hff) drop_count <= drop_count + 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk        (clk),
    .rst_n      (reset_in),
    .data       (ser_data),
    .data_valid (ser_valid),
    .data_ready (ser_ready),
    .byte_done  (ser_done),
    .idle       (ser_idle),
    .txd        (txd)
  );

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Testbench for golden_nonce_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
// A background receiver decodes frames from txd independently of the DUT.
module tb_golden_nonce_uart_tx;

  localparam int B     = 4;
  localparam int FRAME = 40 * B;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] golden_nonce;
  logic        golden_nonce_valid;
  logic        txd, busy, fifo_full, overflow;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  golden_nonce_uart_tx #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (4)
  ) dut (
    .clk                (clk),
    .reset_in           (reset_in),
    .golden_nonce       (golden_nonce),
    .golden_nonce_valid (golden_nonce_valid),
    .txd                (txd),
    .busy               (busy),
    .fifo_full          (fifo_full),
    .overflow           (overflow),
    .drop_count         (drop_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] exp;   // bytes in wire order, first byte in [31:24]
  } vec_t;
  vec_t vec [11];

  logic [31:0] rx_q[$];
  int          rx_start_q[$];
  bit          rx_ok_q[$];
  bit          saw_full;

  always @(negedge clk) if (fifo_full === 1'b1) saw_full = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode one frame starting on the first cycle of its start bit.
  task automatic capture();
    logic [31:0] w;
    logic [9:0]  bits;
    logic        v;
    bit          ok;
    int          st;
    ok = 1'b1;
    st = cyc;
    w  = '0;
    for (int by = 0; by < 4; by++) begin
      for (int k = 0; k < 10; k++) begin
        v = txd;
        for (int j = 1; j < B; j++) begin
          step();
          if (reset_in !== 1'b1) return;
          if (txd !== v) ok = 1'b0;
        end
        bits[k] = v;
        step();
        if (reset_in !== 1'b1) return;
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      w = {w[23:0], bits[8:1]};
    end
    rx_q.push_back(w);
    rx_start_q.push_back(st);
    rx_ok_q.push_back(ok);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_in === 1'b1 && txd === 1'b0) capture();
    end
  end

  task automatic send(int v);
    golden_nonce       = vec[v].nonce;
    golden_nonce_valid = 1'b1;
    step();
    golden_nonce_valid = 1'b0;
  endtask

  task automatic wait_low(output int e);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    check("start_seen", {31'b0, txd}, 32'd0);
    e = cyc;
  endtask

  task automatic wait_frames(int n);
    int lim;
    lim = 0;
    while (rx_q.size() < n && lim < 2000) begin
      step();
      lim++;
    end
    check("frames_arrived", rx_q.size(), n);
  endtask

  task automatic check_frame(int idx, int v);
    if (idx < rx_q.size()) begin
      check("frame_word", rx_q[idx], vec[v].exp);
      check("frame_clean", {31'b0, rx_ok_q[idx]}, 32'd1);
    end else begin
      check("frame_present", rx_q.size(), idx + 1);
    end
  endtask

  initial begin
    int          e, n0, base;
    logic [7:0]  fb;

    vec[0]  = '{32'h1afda099, {8'h1a, 8'hfd, 8'ha0, 8'h99}};
    vec[1]  = '{32'h00000001, {8'h00, 8'h00, 8'h00, 8'h01}};
    vec[2]  = '{32'h12345678, {8'h12, 8'h34, 8'h56, 8'h78}};
    vec[3]  = '{32'hdeadbeef, {8'hde, 8'had, 8'hbe, 8'hef}};
    vec[4]  = '{32'ha5a5a5a5, {8'ha5, 8'ha5, 8'ha5, 8'ha5}};
    vec[5]  = '{32'h0f0f0f0f, {8'h0f, 8'h0f, 8'h0f, 8'h0f}};
    vec[6]  = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}};
    vec[7]  = '{32'hffffffff, {8'hff, 8'hff, 8'hff, 8'hff}};
    vec[8]  = '{32'h00ff00ff, {8'h00, 8'hff, 8'h00, 8'hff}};
    vec[9]  = '{32'h3c3c3c3c, {8'h3c, 8'h3c, 8'h3c, 8'h3c}};
    vec[10] = '{32'hcafef00d, {8'hca, 8'hfe, 8'hf0, 8'h0d}};

    golden_nonce       = '0;
    golden_nonce_valid = 1'b0;
    saw_full           = 1'b0;
    reset_in           = 1'b1;
    #1 reset_in = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_txd",        {31'b0, txd},       32'd1);
    check("rst_busy",       {31'b0, busy},      32'd0);
    check("rst_fifo_full",  {31'b0, fifo_full}, 32'd0);
    check("rst_overflow",   {31'b0, overflow},  32'd0);
    check("rst_drop_count", {24'b0, drop_count}, 32'd0);

    // Strobe coinciding with reset release is ignored
    golden_nonce       = 32'h55555555;
    golden_nonce_valid = 1'b1;
    reset_in           = 1'b1;
    step();
    golden_nonce_valid = 1'b0;
    repeat (4) step();
    check("release_strobe_ignored", {31'b0, busy}, 32'd0);

    // Single nonce: latency, first-byte bits, frame length
    n0 = cyc;
    send(0);
    wait_low(e);
    check("latency", e - n0, 32'd2);
    fb = 8'h1a;
    for (int k = 0; k < 8; k++) begin
      while (cyc < e + B + B * k + 2) step();
      check("first_byte_bit", {31'b0, txd}, {31'b0, fb[k]});
    end
    while (cyc < e + FRAME - 1) step();
    check("busy_last_stop_cycle", {31'b0, busy}, 32'd1);
    step();
    check("busy_after_frame", {31'b0, busy}, 32'd0);
    check("txd_after_frame",  {31'b0, txd},  32'd1);
    wait_frames(1);
    check_frame(0, 0);
    if (rx_start_q.size() > 0) check("frame0_start", rx_start_q[0], e);

    // Queue of three on consecutive cycles
    saw_full = 1'b0;
    base = rx_q.size();
    for (int i = 1; i <= 3; i++) send(i);
    wait_frames(base + 3);
    for (int i = 0; i < 3; i++) check_frame(base + i, i + 1);
    for (int i = 0; i < 2; i++)
      if (base + i + 1 < rx_start_q.size())
        check("interframe_gap", rx_start_q[base+i+1] - rx_start_q[base+i], FRAME + 1);
    check("queue3_never_full", {31'b0, saw_full}, 32'd0);

    // Overflow: six strobes while idle, sixth is dropped
    base = rx_q.size();
    for (int i = 4; i <= 9; i++) send(i);
    check("ovf_overflow",   {31'b0, overflow},   32'd1);
    check("ovf_drop_count", {24'b0, drop_count}, 32'd1);
    check("ovf_fifo_full",  {31'b0, fifo_full},  32'd1);
    wait_frames(base + 5);
    for (int i = 0; i < 5; i++) check_frame(base + i, i + 4);
    repeat (FRAME + 40) step();
    check("ovf_exactly_five", rx_q.size(), base + 5);
    check("ovf_idle_after",   {31'b0, busy}, 32'd0);

    // Push while full on the pop cycle is accepted
    base = rx_q.size();
    send(4);
    wait_low(e);
    while (cyc < e + 10) step();
    for (int i = 5; i <= 8; i++) send(i);
    check("fill_fifo_full", {31'b0, fifo_full}, 32'd1);
    while (cyc < e + FRAME) step();
    golden_nonce       = vec[2].nonce;
    golden_nonce_valid = 1'b1;
    step();
    golden_nonce_valid = 1'b0;
    check("popcycle_still_full",  {31'b0, fifo_full},  32'd1);
    check("popcycle_drop_count",  {24'b0, drop_count}, 32'd1);
    wait_frames(base + 6);
    for (int i = 0; i < 5; i++) check_frame(base + i, i + 4);
    check_frame(base + 5, 2);
    if (base + 1 < rx_start_q.size())
      check("popcycle_gap", rx_start_q[base+1] - rx_start_q[base], FRAME + 1);

    // Mid-frame reset during DATA of the third byte
    wait_frames(base + 6);
    repeat (FRAME + 8) step();
    send(3);
    send(2);
    wait_low(e);
    while (cyc < e + 90) step();
    #2 reset_in = 1'b0;
    #1;
    check("midrst_txd",        {31'b0, txd},        32'd1);
    check("midrst_busy",       {31'b0, busy},       32'd0);
    check("midrst_fifo_full",  {31'b0, fifo_full},  32'd0);
    check("midrst_overflow",   {31'b0, overflow},   32'd0);
    check("midrst_drop_count", {24'b0, drop_count}, 32'd0);
    step();
    step();
    reset_in = 1'b1;
    step();
    base = rx_q.size();
    send(10);
    wait_frames(base + 1);
    check_frame(base, 10);
    repeat (FRAME + 20) step();
    check("midrst_no_stale_frames", rx_q.size(), base + 1);
    check("midrst_idle_after",      {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
